// File: rtl/ifu_if.sv
// Fetch-unit bus: memory request/response, instruction hand-off to execute,
// and the PC/status outputs of the fetch unit.
interface ifu_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        pc_sel;
  logic [63:0] alu_result;
  logic        ebreak_flag;
  logic [63:0] pc;
  logic        halted;
  logic        fault;
  logic [63:0] retired;

  modport master (
    output req_valid, req_addr, inst, inst_valid, pc, halted, fault, retired,
    input  req_ready, resp_valid, resp_data, resp_err, inst_ready, pc_sel,
           alu_result, ebreak_flag
  );

  modport slave (
    input  req_valid, req_addr, inst, inst_valid, pc, halted, fault, retired,
    output req_ready, resp_valid, resp_data, resp_err, inst_ready, pc_sel,
           alu_result, ebreak_flag
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: requests one instruction at a time, holds it until
// execute retires it, then advances the PC; stops for good on ebreak or error.
module ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic  clk,
  input  logic  rst,
  ifu_if.master bus_io
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID,
    HALT,
    FAULT
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q;
  logic [63:0] pc_q;
  logic [63:0] pc_d;
  logic [31:0] inst_q;
  logic [63:0] retired_q;
  logic        req_valid_q;
  logic        inst_valid_q;
  logic        halted_q;
  logic        fault_q;

  // Jump targets always have bit 0 cleared; bit 1 set is caught as misaligned.
  always_comb begin
    pc_d = pc_q + 64'd4;
    if (bus_io.pc_sel) begin
      pc_d = bus_io.alu_result & ~64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= NOP;
      retired_q    <= 64'd0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q     <= REQ;
          req_valid_q <= 1'b1;
        end
        REQ: begin
          if (bus_io.req_ready) begin
            state_q     <= WAIT;
            req_valid_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus_io.resp_valid) begin
            if (bus_io.resp_err) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q      <= VALID;
              inst_q       <= bus_io.resp_data;
              inst_valid_q <= 1'b1;
            end
          end
        end
        VALID: begin
          // Retire: ebreak takes priority over a misaligned next PC.
          if (bus_io.inst_ready) begin
            retired_q    <= retired_q + 64'd1;
            inst_valid_q <= 1'b0;
            if (bus_io.ebreak_flag) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else if (pc_d[1]) begin
              state_q <= FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q     <= REQ;
              pc_q        <= pc_d;
              req_valid_q <= 1'b1;
            end
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        FAULT: begin
          state_q <= FAULT;
        end
        default: begin
          state_q      <= IDLE;
          req_valid_q  <= 1'b0;
          inst_valid_q <= 1'b0;
          halted_q     <= 1'b0;
          fault_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.req_valid  = req_valid_q;
  assign bus_io.req_addr   = pc_q;
  assign bus_io.inst       = inst_q;
  assign bus_io.inst_valid = inst_valid_q;
  assign bus_io.pc         = pc_q;
  assign bus_io.halted     = halted_q;
  assign bus_io.fault      = fault_q;
  assign bus_io.retired    = retired_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed boot/backpressure/jump/ebreak/error/reset
// scenarios plus randomized fetches, checked against a PC/retire-count model.
module tb_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ifu_if bus ();

  ifu #(.RESET_PC(RESET_PC)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Architectural expectation: what the fetch unit should be showing right now.
  logic [63:0] expPc;
  logic [63:0] expRetired;
  logic [31:0] expInst;
  logic        expHalted;
  logic        expFault;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWord(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic quietInputs();
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_data   = 32'd0;
    bus.resp_err    = 1'b0;
    bus.inst_ready  = 1'b0;
    bus.pc_sel      = 1'b0;
    bus.alu_result  = 64'd0;
    bus.ebreak_flag = 1'b0;
  endtask

  // Random noise on inputs that must be ignored in the current state.
  task automatic junkInputs(input bit allowInstReady);
    bus.resp_valid  = 1'($urandom);
    bus.resp_data   = $urandom;
    bus.resp_err    = 1'($urandom);
    bus.pc_sel      = 1'($urandom);
    bus.alu_result  = {$urandom, $urandom};
    bus.ebreak_flag = 1'($urandom);
    bus.inst_ready  = allowInstReady ? 1'($urandom) : 1'b0;
  endtask

  task automatic checkStopped(input string tag);
    checkBit({tag, "_reqValid"}, bus.req_valid, 1'b0);
    checkBit({tag, "_instValid"}, bus.inst_valid, 1'b0);
    checkBit({tag, "_halted"}, bus.halted, expHalted);
    checkBit({tag, "_fault"}, bus.fault, expFault);
    checkWord({tag, "_pc"}, bus.pc, expPc);
    checkWord({tag, "_retired"}, bus.retired, expRetired);
  endtask

  task automatic holdStopped(input string tag);
    repeat (3) begin
      junkInputs(1'b1);
      bus.req_ready = 1'($urandom);
      tick();
      checkStopped(tag);
    end
    quietInputs();
  endtask

  task automatic checkResetValues(input string tag);
    checkBit({tag, "_reqValid"}, bus.req_valid, 1'b0);
    checkBit({tag, "_instValid"}, bus.inst_valid, 1'b0);
    checkBit({tag, "_halted"}, bus.halted, 1'b0);
    checkBit({tag, "_fault"}, bus.fault, 1'b0);
    checkWord({tag, "_pc"}, bus.pc, RESET_PC);
    checkWord({tag, "_reqAddr"}, bus.req_addr, RESET_PC);
    checkWord({tag, "_inst"}, 64'(bus.inst), 64'(NOP));
    checkWord({tag, "_retired"}, bus.retired, 64'd0);
  endtask

  // Reset, release, and step into the first request.
  task automatic doReset();
    quietInputs();
    rst = 1'b1;
    #1;
    checkResetValues("reset");
    tick();
    tick();
    rst = 1'b0;
    expPc      = RESET_PC;
    expRetired = 64'd0;
    expInst    = NOP;
    expHalted  = 1'b0;
    expFault   = 1'b0;
    checkBit("idle_reqValid", bus.req_valid, 1'b0);
    tick();
  endtask

  // One full fetch/retire transaction, starting with the unit in its request phase.
  task automatic applyStimulus(input logic [31:0] data, input int readyDelay,
                               input int respDelay, input int holdCycles,
                               input logic pcSel, input logic [63:0] alu,
                               input logic ebreak);
    logic [63:0] nextPc;
    checkBit("req_valid", bus.req_valid, 1'b1);
    checkWord("req_addr", bus.req_addr, expPc);
    repeat (readyDelay) begin
      junkInputs(1'b1);
      bus.req_ready = 1'b0;
      tick();
      checkBit("backpressure_reqValid", bus.req_valid, 1'b1);
      checkWord("backpressure_reqAddr", bus.req_addr, expPc);
    end
    quietInputs();
    bus.req_ready = 1'b1;
    tick();
    quietInputs();
    checkBit("wait_reqValid", bus.req_valid, 1'b0);
    checkBit("wait_instValid", bus.inst_valid, 1'b0);
    repeat (respDelay) begin
      bus.inst_ready  = 1'($urandom);
      bus.pc_sel      = 1'($urandom);
      bus.ebreak_flag = 1'($urandom);
      bus.alu_result  = {$urandom, $urandom};
      tick();
      checkBit("wait_instValid", bus.inst_valid, 1'b0);
      checkWord("wait_retired", bus.retired, expRetired);
    end
    quietInputs();
    bus.resp_valid = 1'b1;
    bus.resp_data  = data;
    tick();
    quietInputs();
    expInst = data;
    checkBit("valid_instValid", bus.inst_valid, 1'b1);
    checkWord("valid_inst", 64'(bus.inst), 64'(expInst));
    checkWord("valid_pc", bus.pc, expPc);
    repeat (holdCycles) begin
      junkInputs(1'b0);
      tick();
      checkBit("hold_instValid", bus.inst_valid, 1'b1);
      checkWord("hold_inst", 64'(bus.inst), 64'(expInst));
      checkWord("hold_pc", bus.pc, expPc);
      checkWord("hold_retired", bus.retired, expRetired);
    end
    quietInputs();
    bus.inst_ready  = 1'b1;
    bus.pc_sel      = pcSel;
    bus.alu_result  = alu;
    bus.ebreak_flag = ebreak;
    nextPc = pcSel ? (alu - (alu % 64'd2)) : (expPc + 64'd4);
    expRetired = expRetired + 64'd1;
    if (ebreak) expHalted = 1'b1;
    else if ((nextPc % 64'd4) >= 64'd2) expFault = 1'b1;
    else expPc = nextPc;
    tick();
    quietInputs();
    checkWord("retire_retired", bus.retired, expRetired);
    checkBit("retire_instValid", bus.inst_valid, 1'b0);
    checkBit("retire_halted", bus.halted, expHalted);
    checkBit("retire_fault", bus.fault, expFault);
    checkWord("retire_pc", bus.pc, expPc);
    checkBit("retire_reqValid", bus.req_valid, !(expHalted || expFault));
    if (expHalted || expFault) holdStopped("stopped");
  endtask

  task automatic errorFetch();
    checkBit("err_reqValid", bus.req_valid, 1'b1);
    bus.req_ready = 1'b1;
    tick();
    quietInputs();
    bus.resp_valid = 1'b1;
    bus.resp_err   = 1'b1;
    bus.resp_data  = $urandom;
    tick();
    quietInputs();
    expFault = 1'b1;
    checkStopped("errResp");
    checkWord("errResp_inst", 64'(bus.inst), 64'(expInst));
    holdStopped("errStopped");
  endtask

  task automatic resetMidWait();
    checkBit("rstWait_reqValid", bus.req_valid, 1'b1);
    bus.req_ready = 1'b1;
    tick();
    quietInputs();
    checkBit("rstWait_inWait", bus.req_valid, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("asyncReset");
    tick();
    rst = 1'b0;
    bus.resp_valid = 1'b1;
    bus.resp_data  = 32'hDEAD_BEEF;
    expPc      = RESET_PC;
    expRetired = 64'd0;
    expInst    = NOP;
    expHalted  = 1'b0;
    expFault   = 1'b0;
    checkResetValues("lateResp_idle");
    tick();
    checkBit("lateResp_reqValid", bus.req_valid, 1'b1);
    checkWord("lateResp_reqAddr", bus.req_addr, RESET_PC);
    checkBit("lateResp_instValid", bus.inst_valid, 1'b0);
    checkWord("lateResp_inst", 64'(bus.inst), 64'(NOP));
    quietInputs();
  endtask

  initial begin
    logic [63:0] target;
    quietInputs();
    #2;
    doReset();

    // Boot, backpressure, and a jump with bit 0 set in the target.
    applyStimulus(32'h0000_0513, 0, 2, 0, 1'b0, 64'd0, 1'b0);
    applyStimulus($urandom, 5, 1, 4, 1'b0, 64'd0, 1'b0);
    applyStimulus($urandom, 0, 0, 0, 1'b1, 64'h0000_0000_8000_0101, 1'b0);

    for (int i = 0; i < 6; i++) begin
      target = expPc + 64'($urandom_range(0, 15)) * 64'd4 + 64'($urandom_range(0, 1));
      applyStimulus($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom), target, 1'b0);
    end

    // PC wraps past the top of the address space.
    applyStimulus($urandom, 0, 1, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    applyStimulus($urandom, 1, 0, 1, 1'b0, 64'd0, 1'b0);
    checkWord("wrap_pc", bus.pc, 64'd0);

    // Misaligned jump target faults.
    applyStimulus($urandom, 0, 0, 0, 1'b1, 64'h0000_0000_8000_0102, 1'b0);

    // Ebreak beats a misaligned target.
    doReset();
    applyStimulus($urandom, 0, 1, 0, 1'b1, 64'h0000_0000_0000_0002, 1'b1);

    // Error response.
    doReset();
    applyStimulus($urandom, 1, 1, 1, 1'b0, 64'd0, 1'b0);
    errorFetch();

    // Reset in the middle of an outstanding fetch.
    doReset();
    applyStimulus($urandom, 0, 0, 0, 1'b0, 64'd0, 1'b0);
    resetMidWait();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, the PC loaded on reset.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, asynchronous and active-high.
REQ-004 Port req_valid  output  1  fetch request valid.
REQ-005 Port req_ready  input  1  memory accepts request.
REQ-006 Port req_addr  output  64  fetch address, always equal to pc.
REQ-007 Port resp_valid  input  1  memory response valid.
REQ-008 Port resp_data  input  32  fetched instruction word.
REQ-009 Port resp_err  input  1  memory access error, qualified by resp_valid.
REQ-010 Port inst  output  32  instruction presented to control/execute.
REQ-011 Port inst_valid  output  1  inst holds a valid instruction.
REQ-012 Port inst_ready  input  1  execute retires inst this cycle.
REQ-013 Port pc_sel  input  1  next-PC select: 0 = pc+4, 1 = alu_result; sampled only on retire.
REQ-014 Port alu_result  input  64  jump target; sampled only on retire.
REQ-015 Port ebreak_flag  input  1  retiring instruction is ebreak; sampled only on retire.
REQ-016 Port pc  output  64  address of the current instruction.
REQ-017 Port halted  output  1  fetch stopped by ebreak.
REQ-018 Port fault  output  1  fetch stopped by an error or misaligned target.
REQ-019 Port retired  output  64  count of retired instructions.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, REQ, WAIT, VALID, HALT and FAULT.
REQ-021 IDLE SHALL go to REQ unconditionally after one cycle.
REQ-022 In REQ, req_valid SHALL be 1 and req_addr SHALL equal pc.
- req_valid&&req_ready -> WAIT.
- Otherwise remain in REQ with req_addr stable.
REQ-023 In every state other than REQ, req_valid SHALL be 0.
REQ-024 In WAIT, resp_valid&&!resp_err SHALL capture resp_data into inst and go to VALID.
REQ-025 In WAIT, resp_valid&&resp_err SHALL go to FAULT.
REQ-026 A resp_valid received in any state other than WAIT SHALL be ignored.
REQ-027 In VALID, inst_valid SHALL be 1; inst and pc SHALL stay stable until retire.
REQ-028 A retire is inst_valid&&inst_ready.
REQ-029 On retire, retired SHALL increment by 1, wrapping modulo 2^64.
REQ-030 On retire, the next PC SHALL be pc+4 (modulo 2^64) if pc_sel=0, else {alu_result[63:1],1'b0}.
REQ-031 On retire, the next state SHALL be:
- HALT if ebreak_flag=1 (pc unchanged);
- FAULT if the next PC has bit 1 set (pc unchanged);
- REQ otherwise, with pc updated.
REQ-032 If ebreak_flag=1 and the next PC is misaligned on the same retire, ebreak SHALL win (HALT).
REQ-033 HALT and FAULT SHALL be terminal until rst, with req_valid=0 and inst_valid=0.
REQ-034 halted SHALL be 1 only in HALT; fault SHALL be 1 only in FAULT.
REQ-035 Fetch-to-valid latency SHALL be one cycle after resp_valid; retire-to-next-request SHALL be one cycle.
REQ-036 pc_sel, alu_result, ebreak_flag and inst_ready SHALL have no effect outside VALID.

Reset
REQ-037 Assertion of rst SHALL immediately, independent of clk, force the following values:
- state=IDLE, pc=RESET_PC, inst=32'h0000_0013, retired=0;
- req_valid=0, inst_valid=0, halted=0, fault=0.
REQ-038 A reset asserted in WAIT SHALL discard the outstanding fetch, and a late resp_valid after reset SHALL be ignored.
REQ-039 The first request after rst deasserts SHALL carry req_addr=RESET_PC.

Verification
REQ-040 Boot: release rst; req_ready=1; resp after 2 cycles with 32'h00000513 -> req_addr=0x80000000, inst_valid=1 one cycle after resp; retire -> next req_addr=0x80000004, retired=1.
REQ-041 Backpressure: hold req_ready=0 for 5 cycles -> req_valid=1 and req_addr stable throughout; inst_ready=0 for 4 cycles in VALID -> inst and pc stable, retired unchanged.
REQ-042 Jump: retire with pc_sel=1, alu_result=0x80000101 -> next req_addr=0x80000100.
- Retire with pc_sel=1, alu_result=0x80000102 -> fault=1, req_valid=0.
REQ-043 Ebreak: retire with ebreak_flag=1, pc_sel=1, alu_result=0x2 -> halted=1, fault=0, pc unchanged, no further requests.
REQ-044 Error/reset: resp_valid=1, resp_err=1 in WAIT -> fault=1; assert rst mid-WAIT, then late resp_valid -> ignored, state IDLE, pc=0x80000000, all outputs at reset values.
